enigma_group_tx: RTL and testbench
==================================

// Module: enigma_group_tx
// PURPOSE
//  Consumer end of the cipher core's byte stream (o_outputData/o_valid). Buffers enciphered
//  letters in a FIFO, formats them into classic 5-letter groups separated by spaces, with an
//  optional CR/LF every N groups. Sends the result as 8N1 UART on o_tx to the host terminal.
// PARAMETERS
//  CLKS_PER_BIT  868    i_clock cycles per UART bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    16     letter FIFO entries; power of two, >= 2
//  GROUP_LEN     5      letters per group
//  LINE_GROUPS   10     groups per line before CR/LF; 0 = never emit CR/LF
// PORTS
//  i_clock      in   1  system clock, all logic on rising edge
//  reset        in   1  asynchronous, active-low reset
//  i_data       in   8  ASCII byte from cipher core
//  i_valid      in   1  strobe: each high cycle offers one byte; no backpressure
//  o_tx         out  1  UART serial line, idle high
//  o_busy       out  1  high while a frame is on the line or FIFO is non-empty
//  o_overflow   out  1  sticky: a letter was dropped because the FIFO was full
//  o_fifo_level out  5  current FIFO occupancy (0..FIFO_DEPTH)
// BEHAVIOUR
//  Reset (reset=0, async): o_tx=1, o_busy=0, o_overflow=0, o_fifo_level=0, FSM=IDLE,
//   letter/group counters=0, FIFO emptied. Reset mid-frame aborts it; o_tx goes high at once.
//  Input filter: only 0x41..0x5A (A-Z) are pushed. Any other byte is dropped silently and
//   does not set o_overflow.
//  FIFO: push when i_valid & letter & (!full | pop this cycle). Push when full with no pop
//   drops the byte and sets o_overflow, which stays high until reset. o_fifo_level is registered.
//  Byte selection, evaluated only in IDLE with FIFO non-empty. Separators are lazy: they are
//   emitted only once the next letter exists, so the stream never ends with a separator.
//   - letter_cnt < GROUP_LEN: pop letter, send it, letter_cnt++.
//   - letter_cnt == GROUP_LEN and (LINE_GROUPS==0 or group_cnt+1 < LINE_GROUPS):
//     send 0x20 (no pop), letter_cnt=0, group_cnt++.
//   - letter_cnt == GROUP_LEN and group_cnt+1 == LINE_GROUPS: send 0x0D, then 0x0A
//     (back-to-back frames, no pop), letter_cnt=0, group_cnt=0.
//  FSM states: IDLE -> START -> DATA -> STOP -> (CRLF_LF | IDLE).
//   IDLE   : o_tx=1. Loads the shift register on the cycle the selection above fires.
//   START  : o_tx=0 for CLKS_PER_BIT cycles.
//   DATA   : 8 bits, LSB first, CLKS_PER_BIT cycles each. 3-bit index wraps 7->done.
//   STOP   : o_tx=1 for CLKS_PER_BIT cycles. Goes to CRLF_LF if 0x0D was just sent.
//   CRLF_LF: loads 0x0A and goes to START the next cycle. It ignores the FIFO.
//  Latency: the first letter into an empty, idle block gives a start-bit edge on o_tx 2 cycles
//   after the i_valid cycle (1 cycle for the FIFO write, 1 for the IDLE load). A back-to-back
//   frame gap is 1 idle cycle.
//  Baud counter: ceil(log2(CLKS_PER_BIT)) bits, counts 0..CLKS_PER_BIT-1, clears on each
//   state change.
//  Simultaneous push and pop on a full FIFO: both happen, no overflow, level unchanged.
//  o_busy = (state != IDLE) | (fifo_level != 0), registered.
// STRUCTURE
//  Shared package enigma_pkg: ASCII_A=8'h41, ASCII_Z=8'h5A, ASCII_SP=8'h20, ASCII_CR=8'h0D,
//   ASCII_LF=8'h0A, and the tx state enum (IDLE, START, DATA, STOP, CRLF_LF).
//  One sub-module: enigma_byte_fifo (synchronous FIFO, depth/width params, full/empty/level,
//   async active-low reset). Selection, FSM and baud counter stay in this module.
// TESTING  (bench: CLKS_PER_BIT=4, FIFO_DEPTH=4, GROUP_LEN=5, LINE_GROUPS=2)
//  1 Single 'Q'(0x51) strobe -> o_tx low 2 cycles later; decoded frame 0x51; 40 cycles/frame;
//    o_busy falls after stop; no trailing space.
//  2 "ABCDEFGHIJKL" spaced >= 1 frame apart -> line "ABCDE FGHIJ\r\nKL", no trailing separator.
//  3 i_valid bytes 0x61, 0x31, 0x41 -> only "A" transmitted; o_overflow stays 0.
//  4 Six letters on consecutive cycles while idle -> first popped at once, next 4 fill the FIFO,
//    6th dropped; o_overflow=1 and held; "ABCDE" sent.
//  5 Assert reset for 1 cycle during DATA bit 3 -> o_tx=1 immediately; level=0; counters=0;
//    next letter starts a fresh group (no leading space).
//  6 Full FIFO plus push coinciding with the IDLE pop -> no drop; o_fifo_level stays 4.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma group transmitter.
// ASCII codes, tx FSM state enum and a letter classifier.
package enigma_pkg;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CRLF_LF
    } tx_state_t;

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= ASCII_A) && (b <= ASCII_Z);
    endfunction

endpackage

// File: rtl/enigma_group_tx_if.sv
// Byte stream from the cipher core into the group transmitter.
// Strobe-only: no backpressure signal exists.
interface enigma_group_tx_if;

    logic [7:0] i_data;
    logic       i_valid;

    modport master (
        output i_data,
        output i_valid
    );

    modport slave (
        input i_data,
        input i_valid
    );

endinterface

// File: rtl/enigma_byte_fifo.sv
// Synchronous FIFO with registered occupancy and first-word read.
// A write into a full FIFO succeeds only if a read happens the same cycle.
module enigma_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ok,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since level gates every read.
    always_ff @(posedge i_clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(wr_ok) - LW'(rd_ok);
        end
    end

endmodule

// File: rtl/enigma_group_tx.sv
// Formats enciphered letters into 5-letter groups with lazy separators
// and optional CR/LF line breaks, then sends them as 8N1 UART.
module enigma_group_tx
    import enigma_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int GROUP_LEN    = 5,
    parameter int LINE_GROUPS  = 10,
    localparam int LVW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               i_clock,
    input  logic               reset,
    enigma_group_tx_if.slave   cipher,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [LVW-1:0]     o_fifo_level
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(GROUP_LEN + 1);
    localparam int GW = (LINE_GROUPS < 3) ? 1 : $clog2(LINE_GROUPS);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GRP_FULL  = CW'(GROUP_LEN);
    localparam logic [GW-1:0] LINE_LAST =
        GW'((LINE_GROUPS > 0) ? LINE_GROUPS - 1 : 0);

    tx_state_t       state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [CW-1:0]   letter_cnt;
    logic [GW-1:0]   group_cnt;
    logic            sent_cr;

    logic            push_req;
    logic            fifo_wr_ok;
    logic [7:0]      fifo_rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LVW-1:0]  level_nx;

    logic            fire;
    logic            grp_done;
    logic            line_open;
    logic            sel_letter;
    logic            sel_sp;
    logic            sel_cr;
    logic            pop;
    logic [7:0]      load_byte;
    logic            baud_done;
    logic            active_nx;

    assign push_req  = cipher.i_valid && is_letter(cipher.i_data);
    assign baud_done = (baud == BAUD_LAST);
    assign pop       = sel_letter;
    assign level_nx  = o_fifo_level + LVW'(fifo_wr_ok) - LVW'(pop);

    enigma_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clock (i_clock),
        .reset   (reset),
        .wr_en   (push_req),
        .wr_data (cipher.i_data),
        .wr_ok   (fifo_wr_ok),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    // Pick the next byte; separators wait until a letter is queued.
    always_comb begin
        fire       = (state == IDLE) && !fifo_empty;
        grp_done   = (letter_cnt == GRP_FULL);
        line_open  = (LINE_GROUPS == 0) || (group_cnt != LINE_LAST);
        sel_letter = fire && !grp_done;
        sel_sp     = fire && grp_done && line_open;
        sel_cr     = fire && grp_done && !line_open;
        load_byte  = fifo_rd_data;
        if (sel_sp) begin
            load_byte = ASCII_SP;
        end else if (sel_cr) begin
            load_byte = ASCII_CR;
        end
    end

    // Whether the FSM will be outside IDLE after this edge.
    always_comb begin
        active_nx = 1'b1;
        case (state)
            IDLE:    active_nx = fire;
            STOP:    active_nx = !baud_done || sent_cr;
            default: active_nx = 1'b1;
        endcase
    end

    // Busy reflects the post-edge FSM state and FIFO occupancy.
    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            o_busy <= 1'b0;
        end else begin
            o_busy <= active_nx || (level_nx != '0);
        end
    end

    // Sticky flag for a letter lost to a full FIFO.
    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            o_overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            o_overflow <= 1'b1;
        end
    end

    // UART framing FSM with group/line counters and registered line.
    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            o_tx       <= 1'b1;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            letter_cnt <= '0;
            group_cnt  <= '0;
            sent_cr    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    baud <= '0;
                    if (fire) begin
                        shreg   <= load_byte;
                        o_tx    <= 1'b0;
                        state   <= START;
                        sent_cr <= sel_cr;
                        if (sel_letter) begin
                            letter_cnt <= letter_cnt + 1'b1;
                        end else begin
                            letter_cnt <= '0;
                        end
                        if (sel_sp) begin
                            group_cnt <= group_cnt + 1'b1;
                        end else if (sel_cr) begin
                            group_cnt <= '0;
                        end
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        o_tx    <= shreg[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            o_tx    <= shreg[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    o_tx <= 1'b1;
                    if (baud_done) begin
                        baud    <= '0;
                        sent_cr <= 1'b0;
                        if (sent_cr) begin
                            state <= CRLF_LF;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                CRLF_LF: begin
                    shreg <= ASCII_LF;
                    baud  <= '0;
                    o_tx  <= 1'b0;
                    state <= START;
                end
                default: begin
                    state <= IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_group_tx.sv
// Randomized and directed bench for enigma_group_tx against a
// frame-position reference model plus a UART line decoder.
module tb_enigma_group_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int GL    = 5;
    localparam int LG    = 2;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       o_tx;
    logic       o_busy;
    logic       o_overflow;
    logic [2:0] o_fifo_level;

    enigma_group_tx_if bus ();

    enigma_group_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .GROUP_LEN    (GL),
        .LINE_GROUPS  (LG)
    ) dut (
        .i_clock      (clk),
        .reset        (rst_n),
        .cipher       (bus),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_fifo_level (o_fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of letters, position within current frame.
    logic [7:0] q[$];
    logic [7:0] m_log[$];
    logic [7:0] d_log[$];
    int         m_pos = -1;
    bit         m_lfw = 0;
    logic [7:0] m_cur = 8'h00;
    int         m_lc = 0;
    int         m_gc = 0;
    bit         m_ovf = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chks(string nm, string act, string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
        end
    endtask

    function automatic string hexq(logic [7:0] qq[$]);
        string r = "";
        foreach (qq[i]) r = $sformatf("%s%02h", r, qq[i]);
        return r;
    endfunction

    function automatic string hexs(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h", r, s[i]);
        return r;
    endfunction

    function automatic logic exp_tx();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic bit m_idle();
        return (m_pos < 0) && !m_lfw && (q.size() == 0);
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_pos = -1;
            m_lfw = 0;
            m_lc  = 0;
            m_gc  = 0;
            m_ovf = 0;
        end else begin
            if (m_pos >= 0) begin
                if (m_pos == FRAME - 1) begin
                    m_log.push_back(m_cur);
                    m_pos = -1;
                    if (m_cur == 8'h0D) m_lfw = 1;
                end else begin
                    m_pos++;
                end
            end else if (m_lfw) begin
                m_lfw = 0;
                m_cur = 8'h0A;
                m_pos = 0;
            end else if (q.size() != 0) begin
                m_pos = 0;
                if (m_lc < GL) begin
                    m_cur = q.pop_front();
                    m_lc++;
                end else if (LG == 0 || m_gc + 1 < LG) begin
                    m_cur = 8'h20;
                    m_lc  = 0;
                    m_gc++;
                end else begin
                    m_cur = 8'h0D;
                    m_lc  = 0;
                    m_gc  = 0;
                end
            end
            if (bus.i_valid && (bus.i_data inside {[8'h41:8'h5A]})) begin
                if (q.size() < DEPTH) q.push_back(bus.i_data);
                else m_ovf = 1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx", 32'(o_tx), 32'(exp_tx()));
            chk("busy", 32'(o_busy),
                32'((m_pos >= 0) || m_lfw || (q.size() != 0)));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("level", 32'(o_fifo_level), 32'(q.size()));
        end
    end

    // UART decoder sampling mid-bit.
    bit         rx_on = 0;
    int         rx_t = 0;
    logic [7:0] rx_b = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (o_tx === 1'b0) begin
                rx_on = 1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB >= 1 && rx_t / CPB <= 8) begin
                    rx_b[rx_t/CPB-1] = o_tx;
                end else if (rx_t / CPB == 9) begin
                    d_log.push_back(rx_b);
                    rx_on = 0;
                end
            end
        end
    end

    task automatic send(logic [7:0] b);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = b;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic send_burst(string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_data  = s[i];
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        d_log.delete();
        m_log.delete();
    endtask

    task automatic drain();
        int n = 0;
        while (!m_idle() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_log(string nm, string exp);
        chks({nm, "_line"}, hexq(d_log), hexs(exp));
        chks({nm, "_model"}, hexq(m_log), hexs(exp));
    endtask

    initial begin
        int n;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single letter latency and frame length.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h51;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("t1_tx_e1", 32'(o_tx), 32'd1);
        chk("t1_lvl_e1", 32'(o_fifo_level), 32'd1);
        @(negedge clk);
        chk("t1_start", 32'(o_tx), 32'd0);
        chk("t1_busy", 32'(o_busy), 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        chk("t1_stop", 32'(o_tx), 32'd1);
        chk("t1_busy_stop", 32'(o_busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_end", 32'(o_busy), 32'd0);
        drain();
        check_log("t1", "Q");

        // Spaced letters: groups, space, CR/LF.
        do_reset();
        begin
            string s = "ABCDEFGHIJKL";
            for (int i = 0; i < s.len(); i++) begin
                send(s[i]);
                repeat (45) @(negedge clk);
            end
        end
        drain();
        check_log("t2", "ABCDE FGHIJ\r\nKL");

        // Non-letters filtered.
        do_reset();
        send_burst("a1A");
        drain();
        check_log("t3", "A");
        chk("t3_ovf", 32'(o_overflow), 32'd0);

        // Overflow on sixth letter.
        do_reset();
        send_burst("ABCDEF");
        chk("t4_ovf", 32'(o_overflow), 32'd1);
        chk("t4_lvl", 32'(o_fifo_level), 32'd4);
        drain();
        check_log("t4", "ABCDE");
        chk("t4_ovf_held", 32'(o_overflow), 32'd1);

        // Reset during data bit 3 of the fifth letter.
        do_reset();
        send_burst("ABCDE");
        n = 0;
        while (!(m_cur == 8'h45 && m_pos == 4 * CPB) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_wait", 32'(n < 2000), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx", 32'(o_tx), 32'd1);
        chk("t5_lvl", 32'(o_fifo_level), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        d_log.delete();
        m_log.delete();
        send(8'h52);
        drain();
        check_log("t5", "R");

        // Push into full FIFO on the same edge as the IDLE pop.
        do_reset();
        send_burst("ABCDE");
        n = 0;
        while (!(m_pos < 0 && !m_lfw && q.size() == DEPTH) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wait", 32'(n < 2000), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h46;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("t6_lvl", 32'(o_fifo_level), 32'd4);
        chk("t6_ovf", 32'(o_overflow), 32'd0);
        chk("t6_tx", 32'(o_tx), 32'd0);
        drain();
        check_log("t6", "ABCDE F");

        // Random traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.i_valid = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) bus.i_data = 8'($urandom_range(0, 255));
            else bus.i_data = 8'(8'h41 + $urandom_range(0, 25));
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        drain();
        chks("rand_line", hexq(d_log), hexq(m_log));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
